// File: rtl/chg_pkg.sv
// Shared types and constants for the change payout controller.
package chg_pkg;

  localparam int AMT_W_DEF       = 4;
  localparam int STOCK_W_DEF     = 4;
  localparam int INIT_STOCK_DEF  = 4;
  localparam int ACK_TIMEOUT_DEF = 8;

  // Coin face values, in 1-unit steps.
  localparam int COIN_2 = 2;
  localparam int COIN_1 = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_EJECT  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAULT  = 3'd4
  } chg_state_e;

endpackage

// File: rtl/chg_stock_cnt.sv
// Per-chute coin stock: saturating up/down counter, loaded with INIT on reset.
// A simultaneous increment and decrement cancel out.
module chg_stock_cnt
  import chg_pkg::*;
#(
  parameter int W    = STOCK_W_DEF,
  parameter int INIT = INIT_STOCK_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] r_cnt;

  // Stock register: refill adds, payout removes, clamped at both ends.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= W'(INIT);
    end else if (i_inc && !i_dec) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + W'(1);
    end else if (i_dec && !i_inc) begin
      if (r_cnt != '0) r_cnt <= r_cnt - W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/chg_payout.sv
// Change payout controller: takes one change amount per transaction and pays it
// greedily as 2-unit then 1-unit coins over a level request / ack handshake.
// Optional build macro: CHG_TIMEOUT_EN adds an ack timeout that parks the
// controller in a sticky FAULT state until reset.
//
// state  | meaning
// IDLE   | ready for a new amount
// SELECT | pick the next coin from remainder and stock (one cycle)
// EJECT  | request held on one chute until the hopper acks
// DONE   | one-cycle done pulse with the unpaid remainder
// FAULT  | hopper stopped acking; left only by reset
module chg_payout
  import chg_pkg::*;
#(
  parameter int AMT_W       = AMT_W_DEF,
  parameter int STOCK_W     = STOCK_W_DEF,
  parameter int INIT_STOCK  = INIT_STOCK_DEF,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               chg_valid,
  input  logic [AMT_W-1:0]   chg_amt,
  output logic               chg_ready,
  output logic               o_2,
  output logic               o_1,
  input  logic               coin_ack,
  input  logic               refill_2,
  input  logic               refill_1,
  output logic [STOCK_W-1:0] stock_2,
  output logic [STOCK_W-1:0] stock_1,
  output logic               busy,
  output logic               done,
  output logic [AMT_W-1:0]   short,
  output logic               fault
);

  chg_state_e r_state;
  chg_state_e w_next;

  logic [AMT_W-1:0]   r_rem;
  logic               r_sel2;
  logic               r_o2;
  logic               r_o1;
  logic               r_done;
  logic [AMT_W-1:0]   r_short;
  logic               r_ready;
  logic               r_busy;

  logic               w_o2_d;
  logic               w_o1_d;
  logic               w_done_d;
  logic [AMT_W-1:0]   w_short_d;
  logic               w_ready_d;
  logic               w_busy_d;

  logic               w_sel2;
  logic               w_sel1;
  logic               w_ack;
  logic               w_tmo;
  logic               w_dec2;
  logic               w_dec1;
  logic [STOCK_W-1:0] w_stock_2;
  logic [STOCK_W-1:0] w_stock_1;

  // Greedy pick: a 2-unit coin whenever it fits and is stocked, else a 1-unit coin.
  assign w_sel2 = (r_rem >= AMT_W'(COIN_2)) && (w_stock_2 != '0);
  assign w_sel1 = !w_sel2 && (r_rem >= AMT_W'(COIN_1)) && (w_stock_1 != '0);

  // An ack only counts while a request is actually on the wire.
  assign w_ack  = (r_state == ST_EJECT) && coin_ack && (r_o2 || r_o1);
  assign w_dec2 = w_ack && r_o2;
  assign w_dec1 = w_ack && r_o1;

`ifdef CHG_TIMEOUT_EN
  localparam int TMO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_fault;

  // Ack timer: loaded on entry to EJECT, counts down each EJECT cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tmo_cnt <= '0;
    end else if ((r_state == ST_SELECT) && (w_next == ST_EJECT)) begin
      r_tmo_cnt <= TMO_W'(ACK_TIMEOUT - 1);
    end else if ((r_state == ST_EJECT) && (r_tmo_cnt != '0)) begin
      r_tmo_cnt <= r_tmo_cnt - TMO_W'(1);
    end
  end

  assign w_tmo = (r_state == ST_EJECT) && (r_tmo_cnt == '0) && !w_ack;

  // Sticky fault flag, raised on the edge that enters FAULT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fault <= 1'b0;
    end else if (w_next == ST_FAULT) begin
      r_fault <= 1'b1;
    end
  end

  assign fault = r_fault;
`else
  assign w_tmo = 1'b0;
  assign fault = 1'b0;

  // ACK_TIMEOUT has no effect in this build; an empty check keeps it referenced.
  if (ACK_TIMEOUT < 1) begin : g_tmo_unused
  end
`endif

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  // Next state and the values the output registers take on the next edge.
  always_comb begin
    w_next    = r_state;
    w_o2_d    = 1'b0;
    w_o1_d    = 1'b0;
    w_done_d  = 1'b0;
    w_short_d = '0;
    case (r_state)
      ST_IDLE: begin
        if (chg_valid && r_ready) w_next = ST_SELECT;
      end
      ST_SELECT: begin
        w_next = (w_sel2 || w_sel1) ? ST_EJECT : ST_DONE;
      end
      ST_EJECT: begin
        if (w_ack) begin
          w_next = ST_SELECT;
        end else if (w_tmo) begin
          w_next = ST_FAULT;
        end else begin
          w_o2_d = r_sel2;
          w_o1_d = !r_sel2;
        end
      end
      ST_DONE: begin
        w_next    = ST_IDLE;
        w_done_d  = 1'b1;
        w_short_d = r_rem;
      end
      ST_FAULT: begin
        w_next = ST_FAULT;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    // Ready only once IDLE has been held for a full cycle, so it never overlaps done.
    w_ready_d = (r_state == ST_IDLE) && (w_next == ST_IDLE);
    w_busy_d  = !w_ready_d;
  end

  // Remainder and chute choice for the coin in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rem  <= '0;
      r_sel2 <= 1'b0;
    end else begin
      if ((r_state == ST_IDLE) && (w_next == ST_SELECT)) begin
        r_rem <= chg_amt;
      end else if (w_ack) begin
        r_rem <= r_rem - (r_o2 ? AMT_W'(COIN_2) : AMT_W'(COIN_1));
      end
      if (r_state == ST_SELECT) r_sel2 <= w_sel2;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_o2    <= 1'b0;
      r_o1    <= 1'b0;
      r_done  <= 1'b0;
      r_short <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_o2    <= w_o2_d;
      r_o1    <= w_o1_d;
      r_done  <= w_done_d;
      r_short <= w_short_d;
      r_ready <= w_ready_d;
      r_busy  <= w_busy_d;
    end
  end

  chg_stock_cnt #(
    .W    (STOCK_W),
    .INIT (INIT_STOCK)
  ) u_stock_2 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (refill_2),
    .i_dec (w_dec2),
    .o_cnt (w_stock_2)
  );

  chg_stock_cnt #(
    .W    (STOCK_W),
    .INIT (INIT_STOCK)
  ) u_stock_1 (
    .clk   (clk),
    .rst   (rst),
    .i_inc (refill_1),
    .i_dec (w_dec1),
    .o_cnt (w_stock_1)
  );

  assign o_2       = r_o2;
  assign o_1       = r_o1;
  assign done      = r_done;
  assign short     = r_short;
  assign chg_ready = r_ready;
  assign busy      = r_busy;
  assign stock_2   = w_stock_2;
  assign stock_1   = w_stock_1;

endmodule

// File: doc/chg_payout.md
# chg_payout

Change payout controller sitting downstream of the vending machine core: accepts a change amount once per transaction and pays it out coin-by-coin to a two-chute hopper (2-unit and 1-unit coins) over a request/acknowledge handshake. Pays greedily, tracks per-chute coin stock, and reports any amount it could not pay. It is the consumer of the vending machine's change output.

## Interface
- `AMT_W`, 4, width of change amount and remaining counter
- `STOCK_W`, 4, width of each chute stock counter (saturates at 2^STOCK_W-1)
- `INIT_STOCK`, 4, stock value loaded into both counters on reset
- `ACK_TIMEOUT`, 8, cycles in EJECT without `coin_ack` before fault (only with macro)
- `clk` in 1 — single clock, rising edge
- `rst` in 1 — asynchronous, active-low reset
- `chg_valid` in 1 — change amount offered
- `chg_amt` in AMT_W — amount to pay, in 1-unit steps
- `chg_ready` out 1 — high only in IDLE
- `o_2` out 1 — eject request, 2-unit chute (level, held until ack)
- `o_1` out 1 — eject request, 1-unit chute (level, held until ack)
- `coin_ack` in 1 — hopper confirms one coin dropped
- `refill_2`, `refill_1` in 1 each — add one coin to that chute's stock this cycle
- `stock_2`, `stock_1` out STOCK_W each — current stock
- `busy` out 1 — not IDLE
- `done` out 1 — one-cycle pulse at end of payout
- `short` out AMT_W — unpaid remainder, valid while `done`=1, else 0
- `fault` out 1 — sticky ack-timeout fault (constant 0 without macro)

## Operation
- States: IDLE, SELECT, EJECT, DONE, FAULT.
- IDLE: `chg_ready`=1; on `chg_valid`&&`chg_ready` load `rem`=`chg_amt`, go SELECT.
- SELECT (one cycle): if `rem`>=2 and `stock_2`>0 → EJECT with `o_2`; else if `rem`>=1 and `stock_1`>0 → EJECT with `o_1`; else → DONE (covers `rem`=0 and stock-exhausted).
- EJECT: exactly one of `o_2`/`o_1` high. On `coin_ack`: `rem` -= 2 or 1, matching stock -= 1, go SELECT. `coin_ack` outside EJECT is ignored.
- DONE (one cycle): `done`=1, `short`=`rem`; then IDLE.
- Stock: refill +1, payout −1; both in the same cycle on the same chute → unchanged. Increment saturates at max; decrement cannot underflow (never ejects from an empty chute).
- Refill is accepted in every state, including FAULT.
- `chg_valid` while not IDLE is ignored (no queuing).
- Reset (any time, including mid-EJECT): state IDLE, `rem`=0, `o_2`=`o_1`=0, `done`=0, `short`=0, `fault`=0, `busy`=0, `chg_ready`=1 after release, both stocks = INIT_STOCK. An in-flight coin is not counted.

## Timing
- All outputs registered.
- Accept edge E0 → SELECT during cycle E0..E0+1 → `o_x` high from edge E0+2.
- `coin_ack` sampled at edge Ea → `o_x` low, stock/`rem` updated at Ea. The next coin's request rises at Ea+2 (one SELECT cycle in between).
- Amount 0: `done` at edge E0+2, `short`=0.
- Amount N paid fully with immediate acks: `done` asserted 2 cycles after the last ack edge.
- `chg_ready` returns high the cycle after `done`.

## Configuration
- `CHG_TIMEOUT_EN` defined:
  - Counter runs in EJECT, cleared on entry.
  - If ACK_TIMEOUT cycles elapse without `coin_ack`: drop `o_x`, go FAULT, `fault`=1 with `chg_ready`=0 and `busy`=1.
  - FAULT is left only by reset. No `done` pulse is issued.
- Not defined:
  - EJECT waits indefinitely; FAULT is unreachable; `fault` tied 0; no counter logic.

## Structure
- Package `chg_pkg`: state enum typedef, AMT_W/STOCK_W defaults, coin value constants (2, 1).
- Sub-module `chg_stock_cnt`: saturating up/down counter with reset load value; instantiated once per chute.

## Test plan
- Stocks 4/4, `chg_amt`=5, immediate acks → `o_2`, `o_2`, `o_1` in that order; `done` with `short`=0; stocks 2/3.
- `stock_2`=0, `stock_1`=3, `chg_amt`=5 → three `o_1`; `done` with `short`=2; `stock_1`=0.
- `chg_amt`=0 → no `o_x`; `done` at E0+2 with `short`=0; `chg_ready` high next cycle.
- `refill_2` on the same edge as `coin_ack` for `o_2` → `stock_2` unchanged. `refill_1` at stock 15 → stays 15.
- `rst` low mid-EJECT with `o_1` high → `o_1`=0 asynchronously; stocks back to 4/4; new `chg_amt`=1 pays normally.
- With `CHG_TIMEOUT_EN`, withhold `coin_ack` → after 8 EJECT cycles `o_x`=0, `fault`=1, `chg_ready`=0; later `chg_valid` is ignored until reset.
